// File: rtl/cpu_led_ctrl_if.sv
// cpu_led_ctrl_if: register-slave bus for cpu_led_ctrl (write strobe, address, data).
interface cpu_led_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/cpu_led_ctrl.sv
// cpu_led_ctrl: memory-mapped LED output register with OUTSET/OUTCLEAR and optional
// blink logic enabled by the CPU_LED_CTRL_BLINK_EN macro.
module cpu_led_ctrl #(
  parameter int               WIDTH       = 8,
  parameter int               PRESCALE_W  = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  cpu_led_ctrl_if.slave    bus,
  output logic [WIDTH-1:0] out_port
);
  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_next;
  logic [WIDTH-1:0] w_out_next;
  logic             w_unused;
  assign w_unused = &{1'b0, bus.writedata};
  assign w_wr = bus.chipselect & ~bus.write_n;
  assign w_wd = bus.writedata[WIDTH-1:0];
  assign w_data_next = (w_wr && bus.address == 3'd0) ? w_wd :
                       (w_wr && bus.address == 3'd4) ? (r_data | w_wd) :
                       (w_wr && bus.address == 3'd5) ? (r_data & ~w_wd) : r_data;
`ifdef CPU_LED_CTRL_BLINK_EN
  logic [WIDTH-1:0]      r_mask;
  logic [WIDTH-1:0]      w_mask_next;
  logic [PRESCALE_W-1:0] r_period;
  logic [PRESCALE_W-1:0] w_period_next;
  logic [PRESCALE_W-1:0] r_cnt;
  logic [PRESCALE_W-1:0] w_cnt_next;
  logic                  r_phase;
  logic                  w_phase_next;
  logic                  w_period_wr;
  logic                  w_hold;
  logic                  w_wrap;
  assign w_period_wr   = w_wr && bus.address == 3'd2;
  assign w_mask_next   = (w_wr && bus.address == 3'd1) ? w_wd : r_mask;
  assign w_period_next = w_period_wr ? bus.writedata[PRESCALE_W-1:0] : r_period;
  // a PERIOD write restarts the blink in phase 1, beating any wrap this cycle
  assign w_hold        = w_period_wr || r_period == '0;
  assign w_wrap        = r_cnt == r_period;
  assign w_cnt_next    = (w_hold || w_wrap) ? '0 : r_cnt + 1'b1;
  assign w_phase_next  = w_hold ? 1'b1 : w_wrap ? ~r_phase : r_phase;
  assign w_out_next    = w_data_next & ~(w_mask_next & {WIDTH{~w_phase_next}});
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask   <= '0;
      r_period <= '0;
      r_cnt    <= '0;
      r_phase  <= 1'b1;
    end else begin
      r_mask   <= w_mask_next;
      r_period <= w_period_next;
      r_cnt    <= w_cnt_next;
      r_phase  <= w_phase_next;
    end
  end
  assign bus.readdata = (bus.address == 3'd0) ? 32'(r_data) :
                        (bus.address == 3'd1) ? 32'(r_mask) :
                        (bus.address == 3'd2) ? 32'(r_period) :
                        (bus.address == 3'd3) ? {31'b0, r_phase} : 32'b0;
`else
  assign w_out_next   = w_data_next;
  assign bus.readdata = (bus.address == 3'd0) ? 32'(r_data) : 32'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= RESET_VALUE;
      out_port <= RESET_VALUE;
    end else begin
      r_data   <= w_data_next;
      out_port <= w_out_next;
    end
  end
endmodule

// File: tb/tb_cpu_led_ctrl.sv
// tb_cpu_led_ctrl: table-driven register checks plus blink/reset sequences.
module tb_cpu_led_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] out_port;
  int         n_pass = 0;
  int         n_tot = 0;
  cpu_led_ctrl_if bus();
  cpu_led_ctrl #(.WIDTH(8), .PRESCALE_W(24), .RESET_VALUE(8'hA5)) dut (
    .clk(clk), .reset(reset), .bus(bus), .out_port(out_port)
  );
  always #5 clk = ~clk;
`ifdef CPU_LED_CTRL_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  typedef struct {
    string       name;
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic chk_rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    chk(name, bus.readdata, exp);
  endtask
  task automatic cyc(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d,
                     input logic [2:0] ra);
    @(negedge clk);
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = d;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = ra;
    #1;
  endtask
  task automatic reset_during_write();
    @(negedge clk);
    reset          = 1'b1;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = 3'd0;
    bus.writedata  = 32'h55;
    @(posedge clk);
    #1;
    reset          = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    #1;
    chk("rst_out", 32'(out_port), 32'hA5);
    chk_rd("rst_data", 3'd0, 32'hA5);
    chk_rd("rst_mask", 3'd1, 32'h0);
    chk_rd("rst_period", 3'd2, 32'h0);
    chk_rd("rst_status", 3'd3, 32'(BLINK));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rst_steady", 32'(out_port), 32'hA5);
    end
  endtask
  initial begin
    logic ph;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'h0;
    vecs[0]  = '{"data_wr",   1'b1, 1'b0, 3'd0, 32'h0F,  3'd0, 8'h0F, 32'h0F};
    vecs[1]  = '{"outset",    1'b1, 1'b0, 3'd4, 32'hF0,  3'd0, 8'hFF, 32'hFF};
    vecs[2]  = '{"outclr",    1'b1, 1'b0, 3'd5, 32'h81,  3'd0, 8'h7E, 32'h7E};
    vecs[3]  = '{"rsv6_wr",   1'b1, 1'b0, 3'd6, 32'hFF,  3'd6, 8'h7E, 32'h0};
    vecs[4]  = '{"wide_wr",   1'b1, 1'b0, 3'd0, 32'h123, 3'd0, 8'h23, 32'h23};
    vecs[5]  = '{"no_cs",     1'b0, 1'b0, 3'd0, 32'hFF,  3'd0, 8'h23, 32'h23};
    vecs[6]  = '{"wn_high",   1'b1, 1'b1, 3'd0, 32'hFF,  3'd0, 8'h23, 32'h23};
    vecs[7]  = '{"outset_rd", 1'b1, 1'b0, 3'd4, 32'h00,  3'd4, 8'h23, 32'h0};
    vecs[8]  = '{"rsv7_wr",   1'b1, 1'b0, 3'd7, 32'hFF,  3'd7, 8'h23, 32'h0};
    vecs[9]  = '{"mask_wr",   1'b1, 1'b0, 3'd1, 32'hFF,  3'd1, 8'h23, BLINK ? 32'hFF : 32'h0};
    vecs[10] = '{"mask_clr",  1'b1, 1'b0, 3'd1, 32'h00,  3'd1, 8'h23, 32'h0};
    vecs[11] = '{"outclr_all",1'b1, 1'b0, 3'd5, 32'hFF,  3'd5, 8'h00, 32'h0};
    vecs[12] = '{"data_5a",   1'b1, 1'b0, 3'd0, 32'h5A,  3'd0, 8'h5A, 32'h5A};
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("init_out", 32'(out_port), 32'hA5);
    chk_rd("init_data", 3'd0, 32'hA5);
    chk_rd("init_mask", 3'd1, 32'h0);
    chk_rd("init_period", 3'd2, 32'h0);
    chk_rd("init_status", 3'd3, 32'(BLINK));
    foreach (vecs[i]) begin
      cyc(vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wdata, vecs[i].raddr);
      chk({vecs[i].name, "_out"}, 32'(out_port), 32'(vecs[i].exp_out));
      chk({vecs[i].name, "_rd"}, bus.readdata, vecs[i].exp_rd);
    end
`ifdef CPU_LED_CTRL_BLINK_EN
    cyc(1'b1, 1'b0, 3'd0, 32'hFF, 3'd3);
    cyc(1'b1, 1'b0, 3'd1, 32'h03, 3'd3);
    cyc(1'b1, 1'b0, 3'd2, 32'h03, 3'd3);
    chk("blink_out", 32'(out_port), 32'hFF);
    chk("blink_status", bus.readdata, 32'h1);
    for (int k = 1; k < 12; k++) begin
      @(posedge clk);
      #1;
      ph = ((k / 4) % 2) == 0;
      chk("blink_out", 32'(out_port), ph ? 32'hFF : 32'hFC);
      chk("blink_status", bus.readdata, 32'(ph));
    end
    cyc(1'b1, 1'b0, 3'd2, 32'h05, 3'd2);
    chk("pwrap_out", 32'(out_port), 32'hFF);
    chk("pwrap_period", bus.readdata, 32'h5);
    chk_rd("pwrap_status", 3'd3, 32'h1);
    for (int j = 1; j < 8; j++) begin
      @(posedge clk);
      #1;
      ph = j < 6;
      chk("p5_out", 32'(out_port), ph ? 32'hFF : 32'hFC);
      chk("p5_status", bus.readdata, 32'(ph));
    end
    reset_during_write();
`else
    cyc(1'b1, 1'b0, 3'd0, 32'h3C, 3'd1);
    cyc(1'b1, 1'b0, 3'd1, 32'hFF, 3'd1);
    chk("nb_mask_rd", bus.readdata, 32'h0);
    cyc(1'b1, 1'b0, 3'd2, 32'h01, 3'd2);
    chk("nb_period_rd", bus.readdata, 32'h0);
    chk_rd("nb_status_rd", 3'd3, 32'h0);
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      chk("nb_steady", 32'(out_port), 32'h3C);
    end
    reset_during_write();
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
